// File: rtl/cond_pkg.sv
// cond_pkg: condition-code enum and NZCV/flag-write bit positions shared by the execute stage.
package cond_pkg;
    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: purely combinational ARM condition-field evaluation against {N,Z,C,V}.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);
    logic n, z, c, v;
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = n == v;
            COND_LT: cond_ex = n != v;
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/cond_exec_stage.sv
// cond_exec_stage: NZCV register, conditional side-effect gating and E->M pipeline register.
// Define COND_EXEC_STATS_EN to add the ExecCount/SquashCount statistics outputs.
module cond_exec_stage
    import cond_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RA_BITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ValidE,
    input  logic [3:0]         CondE,
    input  logic [1:0]         FlagWriteE,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               MemtoRegE,
    input  logic               BranchE,
    input  logic [WIDTH-1:0]   ALUResultE,
    input  logic [3:0]         ALUFlagsE,
    input  logic               NoWriteE,
    input  logic [WIDTH-1:0]   WriteDataE,
    input  logic [RA_BITS-1:0] WA3E,
    input  logic               StallM,
    input  logic               FlushM,
    output logic               previousCflag,
    output logic [3:0]         FlagsQ,
    output logic               BranchTakenE,
    output logic               ValidM,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic               MemtoRegM,
    output logic [WIDTH-1:0]   ALUResultM,
    output logic [WIDTH-1:0]   WriteDataM,
`ifdef COND_EXEC_STATS_EN
    output logic [31:0]        ExecCount,
    output logic [31:0]        SquashCount,
`endif
    output logic [RA_BITS-1:0] WA3M
);
    logic cond_ex, go, pass;
    cond_check u_cond_check (
        .cond   (CondE),
        .flags  (FlagsQ),
        .cond_ex(cond_ex)
    );
    assign pass          = ValidE & cond_ex;
    assign go            = pass & ~StallM & ~FlushM;
    assign BranchTakenE  = pass & BranchE & ~FlushM;
    assign previousCflag = FlagsQ[FLAG_C];
    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsQ <= 4'b0;
        end else begin
            if (go & FlagWriteE[FW_NZ]) FlagsQ[FLAG_N:FLAG_Z] <= ALUFlagsE[FLAG_N:FLAG_Z];
            if (go & FlagWriteE[FW_CV]) FlagsQ[FLAG_C:FLAG_V] <= ALUFlagsE[FLAG_C:FLAG_V];
        end
    end
    // Squashed instructions still advance into M as valid bubbles with no write enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            ValidM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
        end else if (!StallM) begin
            ValidM     <= FlushM ? 1'b0 : ValidE;
            RegWriteM  <= ~FlushM & pass & RegWriteE & ~NoWriteE;
            MemWriteM  <= ~FlushM & pass & MemWriteE;
            MemtoRegM  <= ~FlushM & pass & MemtoRegE;
            ALUResultM <= FlushM ? ALUResultM : ALUResultE;
            WriteDataM <= FlushM ? WriteDataM : WriteDataE;
            WA3M       <= FlushM ? WA3M : WA3E;
        end
    end
`ifdef COND_EXEC_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ExecCount   <= 32'd0;
            SquashCount <= 32'd0;
        end else begin
            if (go) ExecCount <= ExecCount + 32'd1;
            if (ValidE & ~cond_ex & ~StallM & ~FlushM) SquashCount <= SquashCount + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cond_exec_stage.sv
// tb_cond_exec_stage: directed and randomized checks of cond_exec_stage against a behavioural model.
module tb_cond_exec_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ValidE;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic        RegWriteE, MemWriteE, MemtoRegE, BranchE, NoWriteE;
    logic [31:0] ALUResultE, WriteDataE;
    logic [3:0]  ALUFlagsE, WA3E;
    logic        StallM, FlushM;
    logic        previousCflag, BranchTakenE, ValidM, RegWriteM, MemWriteM, MemtoRegM;
    logic [3:0]  FlagsQ, WA3M;
    logic [31:0] ALUResultM, WriteDataM;
`ifdef COND_EXEC_STATS_EN
    logic [31:0] ExecCount, SquashCount;
    logic [31:0] m_exec, m_squash;
`endif
    int total = 0;
    int bad = 0;
    logic [3:0]  m_nzcv;
    logic        m_valid, m_rw, m_mw, m_m2r;
    logic [31:0] m_res, m_wd;
    logic [3:0]  m_wa;
    logic [3:0]  saved_flags;

    always #5 clk = ~clk;

    cond_exec_stage #(.WIDTH(32), .RA_BITS(4)) dut (
        .clk(clk), .reset(reset), .ValidE(ValidE), .CondE(CondE), .FlagWriteE(FlagWriteE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE), .BranchE(BranchE),
        .ALUResultE(ALUResultE), .ALUFlagsE(ALUFlagsE), .NoWriteE(NoWriteE),
        .WriteDataE(WriteDataE), .WA3E(WA3E), .StallM(StallM), .FlushM(FlushM),
        .previousCflag(previousCflag), .FlagsQ(FlagsQ), .BranchTakenE(BranchTakenE),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
`ifdef COND_EXEC_STATS_EN
        .ExecCount(ExecCount), .SquashCount(SquashCount),
`endif
        .WA3M(WA3M)
    );

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cy;
            4'd3:    return !cy;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cy && !z;
            4'd9:    return !cy || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && n == v;
            4'd13:   return z || n != v;
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        reset = 0; ValidE = 0; CondE = 4'd14; FlagWriteE = 0; RegWriteE = 0; MemWriteE = 0;
        MemtoRegE = 0; BranchE = 0; NoWriteE = 0; ALUResultE = 0; WriteDataE = 0;
        ALUFlagsE = 0; WA3E = 0; StallM = 0; FlushM = 0;
    endtask

    task automatic cyc();
        bit ce, go;
        ce = cond_true(CondE, m_nzcv);
        go = ValidE && ce && !StallM && !FlushM;
        #1 chk("branch_taken", {31'b0, BranchTakenE}, {31'b0, ValidE && BranchE && ce && !FlushM});
        @(posedge clk);
        if (reset) begin
            m_nzcv = 0; m_valid = 0; m_rw = 0; m_mw = 0; m_m2r = 0; m_res = 0; m_wd = 0; m_wa = 0;
`ifdef COND_EXEC_STATS_EN
            m_exec = 0; m_squash = 0;
`endif
        end else begin
            if (go && FlagWriteE[1]) m_nzcv[3:2] = ALUFlagsE[3:2];
            if (go && FlagWriteE[0]) m_nzcv[1:0] = ALUFlagsE[1:0];
`ifdef COND_EXEC_STATS_EN
            if (go) m_exec = m_exec + 1;
            if (ValidE && !ce && !StallM && !FlushM) m_squash = m_squash + 1;
`endif
            if (!StallM && FlushM) begin
                m_valid = 0; m_rw = 0; m_mw = 0; m_m2r = 0;
            end else if (!StallM) begin
                m_valid = ValidE;
                m_rw  = ValidE && ce && RegWriteE && !NoWriteE;
                m_mw  = ValidE && ce && MemWriteE;
                m_m2r = ValidE && ce && MemtoRegE;
                m_res = ALUResultE; m_wd = WriteDataE; m_wa = WA3E;
            end
        end
        #1;
        chk("flags", {28'b0, FlagsQ}, {28'b0, m_nzcv});
        chk("prev_c", {31'b0, previousCflag}, {31'b0, m_nzcv[1]});
        chk("valid_m", {31'b0, ValidM}, {31'b0, m_valid});
        chk("regwrite_m", {31'b0, RegWriteM}, {31'b0, m_rw});
        chk("memwrite_m", {31'b0, MemWriteM}, {31'b0, m_mw});
        chk("memtoreg_m", {31'b0, MemtoRegM}, {31'b0, m_m2r});
        chk("aluresult_m", ALUResultM, m_res);
        chk("writedata_m", WriteDataM, m_wd);
        chk("wa3_m", {28'b0, WA3M}, {28'b0, m_wa});
`ifdef COND_EXEC_STATS_EN
        chk("exec_count", ExecCount, m_exec);
        chk("squash_count", SquashCount, m_squash);
`endif
    endtask

    task automatic set_flags(input logic [3:0] f);
        set_idle();
        ValidE = 1; CondE = 4'd14; FlagWriteE = 2'b11; ALUFlagsE = f; NoWriteE = 1;
        cyc();
    endtask

    initial begin
        m_nzcv = 0;
        set_idle();
        reset = 1;
        cyc();
        cyc();
        chk("reset_flags", {28'b0, FlagsQ}, 32'd0);
        chk("reset_valid", {31'b0, ValidM}, 32'd0);
        chk("reset_prevc", {31'b0, previousCflag}, 32'd0);

        set_idle();
        ValidE = 1; CondE = 4'd14; FlagWriteE = 2'b11; ALUFlagsE = 4'b0110; NoWriteE = 1; RegWriteE = 1;
        cyc();
        chk("cmp_flags", {28'b0, FlagsQ}, 32'h6);
        chk("cmp_regwrite", {31'b0, RegWriteM}, 32'd0);

        set_flags(4'b0100);
        set_idle();
        ValidE = 1; CondE = 4'd0; RegWriteE = 1; ALUResultE = 32'h5; WA3E = 4'd3;
        cyc();
        chk("addeq_rw", {31'b0, RegWriteM}, 32'd1);
        chk("addeq_res", ALUResultM, 32'h5);
        CondE = 4'd1;
        cyc();
        chk("addne_rw", {31'b0, RegWriteM}, 32'd0);
        chk("addne_valid", {31'b0, ValidM}, 32'd1);

        set_flags(4'b1001);
        set_idle();
        ValidE = 1; BranchE = 1; CondE = 4'd12;
        #1 chk("gt_taken", {31'b0, BranchTakenE}, 32'd1);
        cyc();
        set_flags(4'b1000);
        set_idle();
        ValidE = 1; BranchE = 1; CondE = 4'd12;
        #1 chk("gt_not_taken", {31'b0, BranchTakenE}, 32'd0);
        cyc();

        saved_flags = FlagsQ;
        set_idle();
        ValidE = 1; FlagWriteE = 2'b11; ALUFlagsE = 4'b0111; RegWriteE = 1; ALUResultE = 32'hABCD;
        StallM = 1;
        cyc();
        chk("stall_flags", {28'b0, FlagsQ}, {28'b0, saved_flags});
        chk("stall_res", ALUResultM, 32'd0);
        StallM = 0; FlushM = 1;
        cyc();
        chk("flush_valid", {31'b0, ValidM}, 32'd0);
        chk("flush_flags", {28'b0, FlagsQ}, {28'b0, saved_flags});
        StallM = 1;
        cyc();

`ifdef COND_EXEC_STATS_EN
        set_idle();
        reset = 1;
        cyc();
        set_idle();
        ValidE = 1; CondE = 4'd14;
        repeat (3) cyc();
        CondE = 4'd15;
        repeat (2) cyc();
        chk("exec3", ExecCount, 32'd3);
        chk("squash2", SquashCount, 32'd2);
`endif

        for (int i = 0; i < 500; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            ValidE     = ($urandom_range(0, 3) != 0);
            CondE      = 4'($urandom);
            FlagWriteE = 2'($urandom);
            RegWriteE  = 1'($urandom);
            MemWriteE  = 1'($urandom);
            MemtoRegE  = 1'($urandom);
            BranchE    = 1'($urandom);
            NoWriteE   = ($urandom_range(0, 3) == 0);
            ALUResultE = $urandom;
            WriteDataE = $urandom;
            ALUFlagsE  = 4'($urandom);
            WA3E       = 4'($urandom);
            StallM     = ($urandom_range(0, 4) == 0);
            FlushM     = ($urandom_range(0, 4) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
